// File: rtl/i2c_types_pkg.sv
// Shared I2C types and bus constants for the target-side responder.
package i2c_types_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } i2c_resp_state_t;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_resp_tx_fifo.sv
// Small synchronous FIFO holding bytes queued for master reads.
// A pop while full frees the slot used by a simultaneous push.
module i2c_resp_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: matches one 7-bit address, delivers written bytes, serves reads from a TX FIFO.
// Drives SDA open-drain only and never stretches SCL.
module i2c_target_responder
    import i2c_types_pkg::*;
#(
    parameter int unsigned               I2C_ADDR_WIDTH = 7,
    parameter int unsigned               I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = 7'h22,
    parameter int unsigned               TX_FIFO_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_strobe,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data,
    input  logic                      tx_wr,
    output logic                      tx_full,
    output logic                      tx_underrun,
    output logic                      busy,
    output logic                      op_read
);

    localparam int unsigned CntW = $clog2(I2C_DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(I2C_DATA_WIDTH - 1);
    localparam int unsigned W = I2C_DATA_WIDTH;

    // Synchronizers reset to the idle-bus level so reset never fakes an edge.
    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

    logic         fifo_pop, fifo_full, fifo_empty;
    logic [W-1:0] fifo_head;

    i2c_resp_tx_fifo #(
        .Width (W),
        .Depth (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_wr),
        .data_i  (tx_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    i2c_resp_state_t state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    // Holds the previous W-1 bits; the current SDA sample completes the byte.
    logic [W-2:0]    shift_q, shift_d;
    logic [W-1:0]    tx_shift_q, tx_shift_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic            phase_q, phase_d;
    logic            sda_q, sda_d;
    logic            rx_strobe_q, rx_strobe_d;
    logic            underrun_q, underrun_d;
    logic            busy_q, busy_d;
    logic            op_read_q, op_read_d;
    logic            load_tx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '1;
            rx_data_q   <= '0;
            phase_q     <= 1'b0;
            sda_q       <= 1'b1;
            rx_strobe_q <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            op_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            phase_q     <= phase_d;
            sda_q       <= sda_d;
            rx_strobe_q <= rx_strobe_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            op_read_q   <= op_read_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        phase_d     = phase_q;
        sda_d       = sda_q;
        rx_strobe_d = 1'b0;
        underrun_d  = 1'b0;
        busy_d      = busy_q;
        op_read_d   = op_read_q;
        load_tx     = 1'b0;
        fifo_pop    = 1'b0;

        if (stop_det) begin
            state_d = StIdle;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[W-3:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            if (shift_q[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDRESS) begin
                                state_d   = StAddrAck;
                                busy_d    = 1'b1;
                                op_read_d = sda_sync_q;
                                phase_d   = 1'b0;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end
                end
                StAddrAck, StWrAck: begin
                    // First falling edge pulls SDA low, the next one releases it.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            sda_d   = I2C_ACK;
                        end else begin
                            phase_d   = 1'b0;
                            sda_d     = 1'b1;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck && op_read_q == I2C_RW_READ) begin
                                load_tx = 1'b1;
                            end else begin
                                state_d = StWrData;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[W-3:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            rx_data_d   = {shift_q, sda_sync_q};
                            rx_strobe_d = 1'b1;
                            state_d     = StWrAck;
                            phase_d     = 1'b0;
                        end
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == LastBit) begin
                            state_d = StRdAck;
                            sda_d   = 1'b1;
                            phase_d = 1'b0;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 1'b1;
                            tx_shift_d = {tx_shift_q[W-2:0], 1'b1};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_sync_q == I2C_ACK) begin
                            phase_d = 1'b1;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end else if (scl_fall && phase_q) begin
                        load_tx = 1'b1;
                    end
                end
                StWaitStop: sda_d = 1'b1;
                default:    state_d = StIdle;
            endcase
        end

        // The byte's MSB appears on SDA in the same cycle the FIFO pops.
        if (load_tx) begin
            state_d    = StRdData;
            bit_cnt_d  = '0;
            phase_d    = 1'b0;
            fifo_pop   = ~fifo_empty;
            underrun_d = fifo_empty;
            tx_shift_d = fifo_empty ? '1 : fifo_head;
        end
    end

    always_comb begin
        sda_o       = (state_q == StRdData) ? tx_shift_q[W-1] : sda_q;
        rx_data     = rx_data_q;
        rx_strobe   = rx_strobe_q;
        tx_full     = fifo_full;
        tx_underrun = underrun_q;
        busy        = busy_q;
        op_read     = op_read_q;
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: a bit-banged I2C master drives the target through write, read and error cases.
module tb_i2c_target_responder;

    localparam time Q = 100ns;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic       tx_underrun;
    logic       busy;
    logic       op_read;
    logic       sda_bus;

    assign sda_bus = sda_m & sda_o;

    always #5ns clk_i = ~clk_i;

    i2c_target_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .tx_underrun (tx_underrun),
        .busy        (busy),
        .op_read     (op_read)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] rx_q[$];
    int underrun_cnt = 0;

    always @(negedge clk_i) begin
        if (rx_strobe) rx_q.push_back(rx_data);
        if (tx_underrun) underrun_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk_i);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk_i);
        tx_wr   = 1'b0;
    endtask

    logic       ack;
    logic [7:0] rd;
    logic [7:0] exp_wr [3] = '{8'h0A, 8'h5C, 8'hFF};
    logic [7:0] exp_rd [3] = '{8'h64, 8'h65, 8'h66};
    logic [7:0] full_rd [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};

    initial begin
        #25ns;
        check_eq("rst_sda", sda_o, 1'b1);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_strobe", rx_strobe, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_op_read", op_read, 1'b0);
        check_eq("rst_tx_full", tx_full, 1'b0);
        check_eq("rst_underrun", tx_underrun, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #Q;

        // Write three bytes to the matching address.
        i2c_start();
        write_byte(8'h44, ack);
        check_eq("wr_addr_ack", ack, 1'b0);
        check_eq("wr_busy", busy, 1'b1);
        check_eq("wr_op_read", op_read, 1'b0);
        for (int i = 0; i < 3; i++) begin
            write_byte(exp_wr[i], ack);
            check_eq("wr_data_ack", ack, 1'b0);
        end
        i2c_stop();
        #Q;
        check_eq("wr_busy_after_stop", busy, 1'b0);
        check_eq("wr_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) check_eq("wr_rx_byte", rx_q[i], exp_wr[i]);
        rx_q.delete();

        // Read three preloaded bytes, NACK the last.
        for (int i = 0; i < 3; i++) push_tx(exp_rd[i]);
        i2c_start();
        write_byte(8'h45, ack);
        check_eq("rd_addr_ack", ack, 1'b0);
        check_eq("rd_op_read", op_read, 1'b1);
        for (int i = 0; i < 3; i++) begin
            read_byte((i == 2) ? 1'b1 : 1'b0, rd);
            check_eq("rd_byte", rd, exp_rd[i]);
        end
        i2c_stop();
        #Q;
        check_eq("rd_underrun", underrun_cnt, 0);
        check_eq("rd_busy_after_stop", busy, 1'b0);
        check_eq("rd_sda_released", sda_o, 1'b1);

        // Wrong address is not acknowledged.
        i2c_start();
        write_byte(8'h46, ack);
        check_eq("bad_addr_nack", ack, 1'b1);
        check_eq("bad_addr_busy", busy, 1'b0);
        i2c_stop();
        #Q;
        check_eq("bad_addr_rx_count", rx_q.size(), 0);

        // Write, repeated START, then read.
        push_tx(8'h99);
        i2c_start();
        write_byte(8'h44, ack);
        check_eq("rs_wr_addr_ack", ack, 1'b0);
        check_eq("rs_op_read_wr", op_read, 1'b0);
        write_byte(8'h11, ack);
        check_eq("rs_wr_data_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h45, ack);
        check_eq("rs_rd_addr_ack", ack, 1'b0);
        check_eq("rs_op_read_rd", op_read, 1'b1);
        read_byte(1'b1, rd);
        check_eq("rs_rd_byte", rd, 8'h99);
        i2c_stop();
        #Q;
        check_eq("rs_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check_eq("rs_rx_byte", rx_q[0], 8'h11);
        rx_q.delete();

        // Read from an empty FIFO.
        i2c_start();
        write_byte(8'h45, ack);
        read_byte(1'b0, rd);
        check_eq("empty_rd0", rd, 8'hFF);
        read_byte(1'b1, rd);
        check_eq("empty_rd1", rd, 8'hFF);
        i2c_stop();
        #Q;
        check_eq("empty_underrun", underrun_cnt, 2);
        underrun_cnt = 0;

        // Reset while the target drives a 0 bit.
        push_tx(8'h12);
        i2c_start();
        write_byte(8'h45, ack);
        check_eq("rst_mid_pre_sda", sda_o, 1'b0);
        rst_i = 1'b1;
        #1ns;
        check_eq("rst_mid_sda", sda_o, 1'b1);
        #50ns;
        check_eq("rst_mid_busy", busy, 1'b0);
        rst_i = 1'b0;
        i2c_stop();
        #Q;
        i2c_start();
        write_byte(8'h44, ack);
        check_eq("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'h3C, ack);
        check_eq("post_rst_data_ack", ack, 1'b0);
        i2c_stop();
        #Q;
        check_eq("post_rst_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check_eq("post_rst_rx_byte", rx_q[0], 8'h3C);
        rx_q.delete();

        // Fill the FIFO, drop an extra push, then drain past empty.
        for (int i = 0; i < 4; i++) push_tx(full_rd[i]);
        check_eq("fifo_full", tx_full, 1'b1);
        push_tx(8'hA5);
        check_eq("fifo_full_drop", tx_full, 1'b1);
        i2c_start();
        write_byte(8'h45, ack);
        for (int i = 0; i < 5; i++) begin
            read_byte((i == 4) ? 1'b1 : 1'b0, rd);
            check_eq("full_rd_byte", rd, full_rd[i]);
        end
        i2c_stop();
        #Q;
        check_eq("full_underrun", underrun_cnt, 1);
        check_eq("full_not_full", tx_full, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
